tqvp_uart_rx: RTL



---
 rtl/tqvp_uart_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tqvp_uart_rx.sv
// 8N1 UART receiver with a runtime baud divider, mid-bit sampling and a
// one-entry receive buffer carrying valid, overrun and framing-error flags.
module tqvp_uart_rx #(
    parameter int COUNT_REG_LEN = 13,
    parameter int PAYLOAD_BITS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rxd,
    input  logic [COUNT_REG_LEN-1:0] baud_divider,
    input  logic                     rx_read,
    input  logic                     err_clear,
    output logic [PAYLOAD_BITS-1:0]  rx_data,
    output logic                     rx_valid,
    output logic                     rx_busy,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     rx_irq
);

    localparam int BIT_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [BIT_W-1:0]         LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [COUNT_REG_LEN-1:0] CNT_ONE  = COUNT_REG_LEN'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic                     r_rxd_meta, r_rxd_s;
    logic [COUNT_REG_LEN-1:0] r_cnt, w_cnt_nxt, w_target;
    logic [BIT_W-1:0]         r_bit_idx, w_bit_idx_nxt;
    logic [PAYLOAD_BITS-1:0]  r_shift, w_shift_nxt;
    logic [PAYLOAD_BITS-1:0]  r_data;
    logic                     r_valid, r_overrun, r_frame_err;
    logic                     w_hit, w_deliver, w_stop_bad, w_accept, w_ovr_set;

    // Both synchroniser flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // START waits half a bit to land in the middle of the start bit; every
    // later sample is a full bit period after the previous one.
    always_comb begin
        if (r_state == S_START) w_target = baud_divider >> 1;
        else                    w_target = baud_divider - CNT_ONE;
    end

    assign w_hit = (r_cnt == w_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_stop_bad    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = '0;
                if (!r_rxd_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_hit) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_rxd_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_hit) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
                    if (r_bit_idx == LAST_BIT) w_state_nxt = S_STOP;
                    else                       w_bit_idx_nxt = r_bit_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (w_hit) begin
                    w_cnt_nxt = '0;
                    w_deliver = 1'b1;
                    if (r_rxd_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_BREAK: begin
                // A line held low must go high again before a new frame counts.
                w_cnt_nxt = '0;
                if (r_rxd_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A read in the delivery cycle frees the slot for the incoming byte.
    assign w_accept  = w_deliver & (~r_valid | rx_read);
    assign w_ovr_set = w_deliver & r_valid & ~rx_read;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (rx_read) begin
                r_valid <= 1'b0;
            end
            r_overrun   <= (r_overrun   & ~err_clear) | w_ovr_set;
            r_frame_err <= (r_frame_err & ~err_clear) | w_stop_bad;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign rx_busy   = (r_state != S_IDLE);
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign rx_irq    = r_valid | r_overrun | r_frame_err;

endmodule
